// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM state encoding and the
// registered memory request (struct fields are sized to the package defaults).
package mem_port_arbiter_pkg;

   localparam int DEF_D_SIZE = 32;
   localparam int DEF_ADDR_W = 32;
   localparam int WIN_W      = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_D,
      RESP
   } arb_state_t;

   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_D_SIZE-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch and data requests, plus the fairness counter
// that forces a fetch grant after MAX_DATA_WINS data wins while fetch waits.
module mem_arb_grant
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_DATA_WINS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             idle,
   input  logic             if_req,
   input  logic             d_req,
   output logic             grant_if,
   output logic             grant_d,
   output logic [WIN_W-1:0] win_cnt
);

   localparam logic [WIN_W-1:0] MAX_WINS = WIN_W'(MAX_DATA_WINS);

   logic [WIN_W-1:0] win_cnt_reg;
   logic [WIN_W-1:0] win_cnt_next;
   logic             fetch_forced;

   always_comb begin
      fetch_forced = if_req && (win_cnt_reg == MAX_WINS);
      grant_d      = idle && d_req && !fetch_forced;
      grant_if     = idle && if_req && !grant_d;
      win_cnt_next = win_cnt_reg;
      if (grant_if) begin
         win_cnt_next = '0;
      end else if (grant_d) begin
         // Only data wins taken while fetch is actually waiting count against it.
         if (!if_req) begin
            win_cnt_next = '0;
         end else if (win_cnt_reg != MAX_WINS) begin
            win_cnt_next = win_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt_reg <= '0;
      end else begin
         win_cnt_reg <= win_cnt_next;
      end
   end

   assign win_cnt = win_cnt_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters.
// Defining MEM_ARB_STATS_EN adds the stat_conflicts / stat_if_stall counters.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int D_SIZE        = DEF_D_SIZE,
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int MAX_DATA_WINS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [D_SIZE-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [D_SIZE-1:0] d_wdata,
   output logic [D_SIZE-1:0] d_rdata,
   output logic              d_done,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [D_SIZE-1:0] mem_wdata,
   input  logic [D_SIZE-1:0] mem_rdata,
   input  logic              mem_ready
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]       stat_conflicts,
   output logic [31:0]       stat_if_stall
`endif
);

   arb_state_t        state_reg;
   arb_state_t        state_next;
   mem_req_t          req_reg;
   logic              mem_req_reg;
   logic [D_SIZE-1:0] if_rdata_reg;
   logic [D_SIZE-1:0] d_rdata_reg;
   logic              if_done_reg;
   logic              d_done_reg;
   logic              idle;
   logic              grant_if;
   logic              grant_d;
   logic [WIN_W-1:0]  win_cnt;
   logic              busy_done;

   assign idle      = (state_reg == IDLE);
   assign busy_done = mem_ready && ((state_reg == BUSY_IF) || (state_reg == BUSY_D));

   mem_arb_grant #(
      .MAX_DATA_WINS(MAX_DATA_WINS)
   ) u_grant (
      .clk     (clk),
      .reset   (reset),
      .idle    (idle),
      .if_req  (if_req),
      .d_req   (d_req),
      .grant_if(grant_if),
      .grant_d (grant_d),
      .win_cnt (win_cnt)
   );

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (grant_d) begin
               state_next = BUSY_D;
            end else if (grant_if) begin
               state_next = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_D: begin
            if (mem_ready) begin
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         req_reg      <= '0;
         mem_req_reg  <= 1'b0;
         if_rdata_reg <= '0;
         d_rdata_reg  <= '0;
         if_done_reg  <= 1'b0;
         d_done_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         if_done_reg <= mem_ready && (state_reg == BUSY_IF);
         d_done_reg  <= mem_ready && (state_reg == BUSY_D);
         if (grant_d) begin
            req_reg.we    <= d_we;
            req_reg.addr  <= d_addr;
            req_reg.wdata <= d_wdata;
            mem_req_reg   <= 1'b1;
         end else if (grant_if) begin
            req_reg.we   <= 1'b0;
            req_reg.addr <= if_addr;
            mem_req_reg  <= 1'b1;
         end
         if (busy_done) begin
            mem_req_reg <= 1'b0;
            req_reg.we  <= 1'b0;
            if (state_reg == BUSY_IF) begin
               if_rdata_reg <= mem_rdata;
            end else if (!req_reg.we) begin
               d_rdata_reg <= mem_rdata;
            end
         end
      end
   end

   assign mem_req   = mem_req_reg;
   assign mem_we    = req_reg.we;
   assign mem_addr  = req_reg.addr;
   assign mem_wdata = req_reg.wdata;
   assign if_rdata  = if_rdata_reg;
   assign d_rdata   = d_rdata_reg;
   assign if_done   = if_done_reg;
   assign d_done    = d_done_reg;
   assign stall_if  = if_req && !if_done_reg;
   assign stall_mem = d_req && !d_done_reg;

`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_conflicts_reg;
   logic [31:0] stat_if_stall_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_conflicts_reg <= '0;
         stat_if_stall_reg  <= '0;
      end else begin
         if (idle && if_req && d_req) begin
            stat_conflicts_reg <= stat_conflicts_reg + 32'd1;
         end
         if (stall_if) begin
            stat_if_stall_reg <= stat_if_stall_reg + 32'd1;
         end
      end
   end

   assign stat_conflicts = stat_conflicts_reg;
   assign stat_if_stall  = stat_if_stall_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model and a behavioural memory.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_conflicts;
   logic [31:0] stat_if_stall;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   int          fixed_lat = 0;
   bit          rand_idle_ready = 1'b0;
   logic [31:0] mem [256];

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .D_SIZE(32), .ADDR_W(32), .MAX_DATA_WINS(MAXW)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef MEM_ARB_STATS_EN
      , .stat_conflicts(stat_conflicts), .stat_if_stall(stat_if_stall)
`endif
   );

   // Behavioural memory: answers mem_req after fixed_lat extra cycles (random if < 0).
   initial begin : responder
      int          wcnt;
      int          rnd_lat;
      bit          wr_pend;
      logic [7:0]  wr_idx;
      logic [31:0] wr_data;
      wcnt = 0; rnd_lat = 0; wr_pend = 1'b0; wr_idx = '0; wr_data = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[64] = 32'h2402000A;
      forever begin
         @(posedge clk);
         if (wr_pend) mem[wr_idx] = wr_data;
         wr_pend = 1'b0;
         #2;
         if (reset) begin
            mem_ready = 1'b0;
            wcnt = 0;
         end else if (mem_req) begin
            if (wcnt >= ((fixed_lat >= 0) ? fixed_lat : rnd_lat)) begin
               mem_ready = 1'b1;
               mem_rdata = mem[mem_addr[9:2]];
               wr_pend   = mem_we;
               wr_idx    = mem_addr[9:2];
               wr_data   = mem_wdata;
               wcnt      = 0;
               rnd_lat   = $urandom_range(0, 3);
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
               wcnt++;
            end
         end else begin
            mem_ready = rand_idle_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
      n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
      n_vec++; if (if_rdata !== 32'h0) begin n_err++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
      n_vec++; if (d_rdata !== 32'h0) begin n_err++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
      n_vec++; if ({if_done, d_done} !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", {if_done, d_done}); end
      n_vec++; if (dut.state_reg !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dut.state_reg, IDLE); end
      n_vec++; if (dut.u_grant.win_cnt_reg !== 4'd0) begin n_err++; $display("FAIL reset_win_cnt: got %0d want 0", dut.u_grant.win_cnt_reg); end
`ifdef MEM_ARB_STATS_EN
      n_vec++; if ({stat_conflicts, stat_if_stall} !== 64'h0) begin n_err++; $display("FAIL reset_stats: got %h/%h want 0/0", stat_conflicts, stat_if_stall); end
`endif
      reset = 1'b0;
      $display("txn reset: released");
   endtask

   task automatic test_fetch_only();
      fixed_lat = 0;
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      n_vec++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c0: got %0b want 1", stall_if); end
      tick();
      n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fetch_mem_req_c1: got %0b want 1", mem_req); end
      n_vec++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL fetch_mem_addr_c1: got %h want 00000100", mem_addr); end
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_mem_we_c1: got %0b want 0", mem_we); end
      n_vec++; if (if_done !== 1'b0) begin n_err++; $display("FAIL fetch_done_c1: got %0b want 0", if_done); end
      #1;
      n_vec++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c1: got %0b want 1", stall_if); end
      tick();
      n_vec++; if (if_done !== 1'b1) begin n_err++; $display("FAIL fetch_done_c2: got %0b want 1", if_done); end
      n_vec++; if (if_rdata !== 32'h2402000A) begin n_err++; $display("FAIL fetch_rdata_c2: got %h want 2402000a", if_rdata); end
      n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL fetch_stall_c2: got %0b want 0", stall_if); end
      if_req = 1'b0;
      tick();
      n_vec++; if (if_done !== 1'b0) begin n_err++; $display("FAIL fetch_done_c3: got %0b want 0", if_done); end
      $display("txn fetch: addr=00000100 data=%h", if_rdata);
   endtask

   task automatic test_data_write();
      int held = 0;
      int dones = 0;
      bit fin = 1'b0;
      fixed_lat = 2;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
      for (int c = 0; c < 20 && !fin; c++) begin
         tick();
         if (mem_req) begin
            held++;
            n_vec++; if (mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF || mem_we !== 1'b1) begin
               n_err++; $display("FAIL write_hold: got addr=%h wdata=%h we=%0b want 00000040/deadbeef/1", mem_addr, mem_wdata, mem_we);
            end
         end
         if (d_done) begin
            dones++; fin = 1'b1; d_req = 1'b0; d_we = 1'b0;
            n_vec++; if (d_rdata !== 32'h0) begin n_err++; $display("FAIL write_rdata: got %h want 0", d_rdata); end
         end
      end
      if (!fin) begin n_vec++; n_err++; $display("FAIL write_timeout: got no d_done want one"); d_req = 1'b0; end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (d_done) dones++;
      end
      n_vec++; if (held != 3) begin n_err++; $display("FAIL write_held: got %0d cycles want 3", held); end
      n_vec++; if (dones != 1) begin n_err++; $display("FAIL write_done_count: got %0d want 1", dones); end
      n_vec++; if (mem[16] !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_mem: got %h want deadbeef", mem[16]); end
      $display("txn write: addr=00000040 data=deadbeef held=%0d", held);
   endtask

   task automatic test_simultaneous();
      int d_at = -1;
      int i_at = -1;
      int dn = 0;
      int in = 0;
      apply_reset();
      fixed_lat = 0;
      if_req = 1'b1; if_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (d_done) begin
            dn++; if (d_at < 0) d_at = c; d_req = 1'b0;
            n_vec++; if (d_rdata !== mem[17]) begin n_err++; $display("FAIL simul_d_rdata: got %h want %h", d_rdata, mem[17]); end
         end
         if (if_done) begin
            in++; if (i_at < 0) i_at = c; if_req = 1'b0;
            n_vec++; if (if_rdata !== 32'h2402000A) begin n_err++; $display("FAIL simul_if_rdata: got %h want 2402000a", if_rdata); end
         end
      end
      n_vec++; if (d_at != 2) begin n_err++; $display("FAIL simul_d_cycle: got %0d want 2", d_at); end
      n_vec++; if (i_at != 5) begin n_err++; $display("FAIL simul_if_cycle: got %0d want 5", i_at); end
      n_vec++; if (dn != 1 || in != 1) begin n_err++; $display("FAIL simul_done_counts: got d=%0d if=%0d want 1/1", dn, in); end
      $display("txn simultaneous: data done c%0d, fetch done c%0d", d_at, i_at);
   endtask

   task automatic test_starvation();
      int d_before = 0;
      int i_at = -1;
      bit fin = 1'b0;
      apply_reset();
      fixed_lat = 0;
      if_req = 1'b1; if_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
      for (int c = 1; c <= 60 && i_at < 0; c++) begin
         tick();
         if (d_done) begin
            d_before++; d_req = 1'b0;
         end else if (!d_req) begin
            d_req = 1'b1;
         end
         if (if_done) begin
            i_at = c; if_req = 1'b0;
            n_vec++; if (dut.u_grant.win_cnt_reg !== 4'd0) begin n_err++; $display("FAIL starve_win_cnt: got %0d want 0", dut.u_grant.win_cnt_reg); end
         end
      end
      n_vec++; if (d_before != MAXW) begin n_err++; $display("FAIL starve_data_wins: got %0d want %0d", d_before, MAXW); end
      n_vec++; if (i_at != 3 * MAXW + 2) begin n_err++; $display("FAIL starve_if_cycle: got %0d want %0d", i_at, 3 * MAXW + 2); end
      for (int c = 0; c < 10 && !fin; c++) begin
         tick();
         if (d_done) begin d_req = 1'b0; fin = 1'b1; end
      end
      if (!fin) begin n_vec++; n_err++; $display("FAIL starve_tail_timeout: got no d_done want one"); d_req = 1'b0; end
      tick();
`ifdef MEM_ARB_STATS_EN
      n_vec++; if (stat_conflicts !== 32'(MAXW + 1)) begin n_err++; $display("FAIL starve_stat_conflicts: got %0d want %0d", stat_conflicts, MAXW + 1); end
      n_vec++; if (stat_if_stall !== 32'(3 * MAXW + 2)) begin n_err++; $display("FAIL starve_stat_if_stall: got %0d want %0d", stat_if_stall, 3 * MAXW + 2); end
`endif
      $display("txn starvation: %0d data grants before fetch, fetch done c%0d", d_before, i_at);
   endtask

   task automatic test_reset_mid();
      bit fin = 1'b0;
      apply_reset();
`ifdef MEM_ARB_STATS_EN
      n_vec++; if ({stat_conflicts, stat_if_stall} !== 64'h0) begin n_err++; $display("FAIL midrst_stats_clear: got %h/%h want 0/0", stat_conflicts, stat_if_stall); end
`endif
      fixed_lat = 10;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
      tick();
      n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL midrst_busy: got mem_req=%0b want 1", mem_req); end
      tick();
      reset = 1'b1;
      tick();
      n_vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL midrst_mem_req: got req=%0b we=%0b want 0/0", mem_req, mem_we); end
      n_vec++; if (d_done !== 1'b0) begin n_err++; $display("FAIL midrst_d_done: got %0b want 0", d_done); end
      n_vec++; if (dut.state_reg !== IDLE) begin n_err++; $display("FAIL midrst_state: got %0d want %0d", dut.state_reg, IDLE); end
      reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
      tick();
      n_vec++; if (d_done !== 1'b0) begin n_err++; $display("FAIL midrst_d_done_after: got %0b want 0", d_done); end
      fixed_lat = 0;
      if_req = 1'b1; if_addr = 32'h100;
      for (int c = 0; c < 10 && !fin; c++) begin
         tick();
         if (if_done) begin
            fin = 1'b1; if_req = 1'b0;
            n_vec++; if (if_rdata !== 32'h2402000A) begin n_err++; $display("FAIL midrst_fetch_rdata: got %h want 2402000a", if_rdata); end
         end
      end
      if (!fin) begin n_vec++; n_err++; $display("FAIL midrst_fetch_timeout: got no if_done want one"); if_req = 1'b0; end
      $display("txn reset_mid: write abandoned, fetch after reset done=%0b", fin);
   endtask

   // Randomized run: the model tracks one outstanding transaction at a time and
   // predicts owner, port values, completion and captured data from the rules.
   task automatic test_random();
      int          ph = 0;
      bit          own_d = 1'b0;
      int          wins = 0;
      logic [31:0] p_addr = '0;
      logic [31:0] p_wdata = '0;
      logic        p_we = 1'b0;
      logic [31:0] e_val = '0;
      logic [31:0] e_if_rdata = '0;
      logic [31:0] e_d_rdata = '0;
      logic [31:0] e_conf = '0;
      logic [31:0] e_stall = '0;
      logic        e_if_done;
      logic        e_d_done;
      int          ntx = 0;
      apply_reset();
      fixed_lat = -1;
      rand_idle_ready = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (if_req && if_done) if_req = 1'b0;
         else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = 32'($urandom_range(0, 255)) << 2;
         end
         if (d_req && d_done) begin d_req = 1'b0; d_we = 1'b0; end
         else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = 32'($urandom_range(0, 255)) << 2; d_wdata = $urandom;
         end
         #2;
         e_if_done = (ph == 2) && !own_d;
         e_d_done  = (ph == 2) && own_d;
         n_vec++; if (mem_req !== (ph == 1)) begin n_err++; $display("FAIL rnd_mem_req c%0d: got %0b want %0b", cyc, mem_req, ph == 1); end
         if (ph == 1) begin
            n_vec++; if (mem_addr !== p_addr || mem_we !== p_we) begin n_err++; $display("FAIL rnd_mem_port c%0d: got addr=%h we=%0b want %h/%0b", cyc, mem_addr, mem_we, p_addr, p_we); end
            if (p_we) begin
               n_vec++; if (mem_wdata !== p_wdata) begin n_err++; $display("FAIL rnd_mem_wdata c%0d: got %h want %h", cyc, mem_wdata, p_wdata); end
            end
         end
         n_vec++; if ({if_done, d_done} !== {e_if_done, e_d_done}) begin n_err++; $display("FAIL rnd_done c%0d: got %b want %b", cyc, {if_done, d_done}, {e_if_done, e_d_done}); end
         n_vec++; if (if_rdata !== e_if_rdata || d_rdata !== e_d_rdata) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h/%h want %h/%h", cyc, if_rdata, d_rdata, e_if_rdata, e_d_rdata); end
         n_vec++; if ({stall_if, stall_mem} !== {if_req && !e_if_done, d_req && !e_d_done}) begin n_err++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, {stall_if, stall_mem}, {if_req && !e_if_done, d_req && !e_d_done}); end
`ifdef MEM_ARB_STATS_EN
         n_vec++; if (stat_conflicts !== e_conf || stat_if_stall !== e_stall) begin n_err++; $display("FAIL rnd_stats c%0d: got %0d/%0d want %0d/%0d", cyc, stat_conflicts, stat_if_stall, e_conf, e_stall); end
`endif
         if (e_if_done || e_d_done) begin
            ntx++;
            $display("txn rnd %0d: %s %s addr=%h data=%h", ntx, own_d ? "data" : "fetch", p_we ? "wr" : "rd", p_addr, p_we ? p_wdata : e_val);
         end
         if (ph == 0 && if_req && d_req) e_conf++;
         if (if_req && !e_if_done) e_stall++;
         case (ph)
            0: begin
               if (if_req || d_req) begin
                  own_d = d_req && !(if_req && wins == MAXW);
                  if (own_d) begin
                     wins    = if_req ? ((wins < MAXW) ? wins + 1 : MAXW) : 0;
                     p_addr  = d_addr; p_we = d_we; p_wdata = d_wdata;
                  end else begin
                     wins    = 0;
                     p_addr  = if_addr; p_we = 1'b0;
                  end
                  e_val = mem[p_addr[9:2]];
                  ph = 1;
               end
            end
            1: begin
               if (mem_ready) begin
                  ph = 2;
                  if (!own_d) e_if_rdata = e_val;
                  else if (!p_we) e_d_rdata = e_val;
               end
            end
            default: ph = 0;
         endcase
         tick();
      end
      rand_idle_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_data_write();
      test_simultaneous();
      test_starvation();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the fetch stage and the memory stage of the 5-stage pipeline.
- Serialises requests and drives the memory port with a req/ready handshake.
- Returns read data and one-cycle completion pulses to each requester.
- Generates the stall signals the pipeline uses to freeze IF and MEM while their access is outstanding.

Parameters:
- D_SIZE, 32, data word width.
- ADDR_W, 32, byte address width.
- MAX_DATA_WINS, 4, consecutive data grants allowed while fetch waits before fetch is forced; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch read request; held with stable if_addr until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  D_SIZE  fetched instruction, valid when if_done.
- if_done  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_done.
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  D_SIZE  store data.
- d_rdata  out  D_SIZE  load data, valid when d_done; unchanged on writes.
- d_done  out  1  one-cycle data completion pulse.
- stall_if  out  1  if_req & ~if_done, combinational.
- stall_mem  out  1  d_req & ~d_done, combinational.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  D_SIZE  memory write data.
- mem_rdata  in  D_SIZE  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current access this cycle.

Behaviour:
- Reset values: state=IDLE; mem_req/mem_we/if_done/d_done=0; mem_addr/mem_wdata/if_rdata/d_rdata=0; win_cnt=0.
- Reset mid-access abandons the transaction with no done pulse; the memory is reset alongside.
- FSM states are IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE: arbitrates among requests sampled this cycle.
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_IF.
  - Both -> BUSY_D, unless win_cnt==MAX_DATA_WINS, in which case -> BUSY_IF.
  - Neither -> stay IDLE.
- On grant, address/we/wdata are registered. mem_req=1 from the next cycle; mem_we=0 for fetch.
- BUSY_x: mem_req and the registered outputs are held stable until mem_ready=1.
  - On that edge: capture mem_rdata into if_rdata (BUSY_IF) or into d_rdata (BUSY_D with we=0). A data write captures nothing.
  - mem_req and mem_we drop to 0; -> RESP.
- RESP: exactly one of if_done/d_done is 1 for this single cycle.
  - Requests are ignored in RESP, so requesters deassert req combinationally on done.
  - -> IDLE.
- Minimum latency: request seen in IDLE at cycle 0; mem_req at cycle 1; mem_ready at cycle 1; done at cycle 2; next grant evaluated at cycle 3.
- Fairness counter win_cnt:
  - Increments on a data grant while if_req=1.
  - Clears on any fetch grant, and on a data grant with if_req=0.
  - Saturates at MAX_DATA_WINS.
- mem_ready outside BUSY_x is ignored.
- A req that drops before done is a protocol violation; the transaction still completes and done still pulses.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs stat_conflicts (32-bit) and stat_if_stall (32-bit), both reset to 0 and wrapping at 2^32.
  - stat_conflicts increments each IDLE cycle with if_req & d_req.
  - stat_if_stall increments each cycle stall_if=1.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- The shared struct package holds:
  - the arb_state_t enum (IDLE, BUSY_IF, BUSY_D, RESP);
  - a mem_req_t struct {we, addr, wdata};
  - D_SIZE/ADDR_W defaults.
- One sub-module, mem_arb_grant: combinational grant decision plus the win_cnt register. The FSM and datapath stay in mem_port_arbiter.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, mem_ready=1 one cycle after mem_req, mem_rdata=0x2402000A -> mem_addr=0x100 and mem_we=0 at cycle 1; if_done=1 with if_rdata=0x2402000A at cycle 2; stall_if high cycles 0-1.
- Data write: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_req held 3 cycles with stable address/data; d_done one pulse; d_rdata unchanged.
- Simultaneous first requests: if_req=d_req=1 -> data granted first, fetch granted immediately after data's RESP; each done pulses exactly once.
- Starvation: if_req held, d_req re-asserted every IDLE -> exactly 4 data grants, then a fetch grant, then win_cnt=0.
- Reset mid-access: assert reset while in BUSY_D with mem_req=1 -> next cycle mem_req=0, no d_done, state IDLE; a new fetch then completes normally.
- With MEM_ARB_STATS_EN: the starvation scenario -> stat_conflicts=5 and stat_if_stall equals the fetch wait cycles; reset clears both to 0.
